// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the 4-slot TDM link. The stream builder (4:1 slot
// selector) and the receive demultiplexer both import this package, so the
// slot count and slot index width are defined exactly once.
//
// Contents:
//   NSLOT, SLOT_W      slot count and slot index width
//   SLOT_* constants   named slot indices used by the counter and the FSM
//   state_t            receiver alignment state {HUNT, LOCK}
//   slot_next()        modulo-NSLOT increment of a slot index
// -----------------------------------------------------------------------------
package tdm_pkg;

   localparam int unsigned NSLOT  = 4;
   localparam int unsigned SLOT_W = 2;

   localparam logic [SLOT_W-1:0] SLOT_FIRST  = SLOT_W'(0);
   localparam logic [SLOT_W-1:0] SLOT_SECOND = SLOT_W'(1);
   localparam logic [SLOT_W-1:0] SLOT_THIRD  = SLOT_W'(2);
   localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(NSLOT - 1);

   // HUNT: waiting for a frame-sync beat. LOCK: slot position is trusted.
   typedef enum logic [0:0] {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   // Next slot index; NSLOT is a power of two so natural wrap is the modulo.
   function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] slot);
      return slot + SLOT_W'(1);
   endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// -----------------------------------------------------------------------------
// tdm_slot_counter
// Slot position counter for the TDM receiver. Counts accepted beats modulo
// NSLOT and exposes the slot index expected on the next accepted beat.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset (counter returns to slot 0)
//   en_i     advance to the next slot (wraps NSLOT-1 -> 0)
//   load1_i  resync: the current beat was slot 0, so the next one is slot 1
//   clr_i    return to slot 0 (alignment lost)
//   sel_o    slot index expected on the next accepted beat
//   last_o   1 when sel_o is the final slot of the frame
//
// Priority when several controls are high: clr_i > load1_i > en_i.
// -----------------------------------------------------------------------------
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              load1_i,
   input  logic              clr_i,
   output logic [SLOT_W-1:0] sel_o,
   output logic              last_o
);

   logic [SLOT_W-1:0] cnt_q;
   logic [SLOT_W-1:0] cnt_d;

   // Next slot index from the clear / resync / advance controls.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = SLOT_FIRST;
      end else if (load1_i) begin
         cnt_d = SLOT_SECOND;
      end else if (en_i) begin
         cnt_d = slot_next(cnt_q);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Slot index register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= SLOT_FIRST;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sel_o  = cnt_q;
   assign last_o = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/tdm_demux_1to4.sv
// -----------------------------------------------------------------------------
// tdm_demux_1to4
// Receive side of a 4-slot time-division channel. One beat per slot arrives
// on IN, slot 0 flagged by FSYNC. Slots 0..2 are held in shadow registers;
// when the slot-3 beat arrives the whole frame is copied to OUT0..OUT3 in one
// edge and OUT_VALID pulses for one cycle. Loss of alignment (missing or early
// frame sync) pulses SYNC_ERR; a missing sync drops back to HUNT, an early
// sync restarts the frame on the new slot 0 while staying locked.
//
// Parameters:
//   WIDTH      data bits per slot / channel (1..32)
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset; release must be synchronous
//              to CLK (provided by the reset synchroniser upstream)
//   IN         slot data beat
//   IN_VALID   IN/FSYNC valid this cycle; low stalls everything
//   FSYNC      marks the slot-0 beat, sampled only with IN_VALID
//   OUT0..3    channels 0..3 of the last complete frame
//   OUT_VALID  one-cycle pulse: OUT0..3 just updated
//   SEL        slot index expected on the next accepted beat
//   LOCKED     frame alignment held
//   SYNC_ERR   one-cycle pulse: alignment violation detected
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module tdm_demux_1to4
   import tdm_pkg::*;
#(
   parameter int unsigned WIDTH = 1
)
(
   input  logic              CLK,
   input  logic              RST,
   input  logic [WIDTH-1:0]  IN,
   input  logic              IN_VALID,
   input  logic              FSYNC,
   output logic [WIDTH-1:0]  OUT0,
   output logic [WIDTH-1:0]  OUT1,
   output logic [WIDTH-1:0]  OUT2,
   output logic [WIDTH-1:0]  OUT3,
   output logic              OUT_VALID,
   output logic [SLOT_W-1:0] SEL,
   output logic              LOCKED,
   output logic              SYNC_ERR
);

   state_t            state_q;
   state_t            state_d;

   logic [WIDTH-1:0]  shadow0_q;
   logic [WIDTH-1:0]  shadow0_d;
   logic [WIDTH-1:0]  shadow1_q;
   logic [WIDTH-1:0]  shadow1_d;
   logic [WIDTH-1:0]  shadow2_q;
   logic [WIDTH-1:0]  shadow2_d;

   logic [WIDTH-1:0]  out0_q;
   logic [WIDTH-1:0]  out0_d;
   logic [WIDTH-1:0]  out1_q;
   logic [WIDTH-1:0]  out1_d;
   logic [WIDTH-1:0]  out2_q;
   logic [WIDTH-1:0]  out2_d;
   logic [WIDTH-1:0]  out3_q;
   logic [WIDTH-1:0]  out3_d;

   logic              out_valid_q;
   logic              out_valid_d;
   logic              sync_err_q;
   logic              sync_err_d;

   logic              cnt_en_s;
   logic              cnt_load1_s;
   logic              cnt_clr_s;
   logic [SLOT_W-1:0] sel_s;
   logic              last_s;
   logic              slot0_s;

   tdm_slot_counter u_slot_counter (
      .clk_i   (CLK),
      .rst_i   (RST),
      .en_i    (cnt_en_s),
      .load1_i (cnt_load1_s),
      .clr_i   (cnt_clr_s),
      .sel_o   (sel_s),
      .last_o  (last_s)
   );

   assign slot0_s = (sel_s == SLOT_FIRST);

   // Alignment FSM, shadow capture and frame publish for one accepted beat.
   always_comb begin
      state_d     = state_q;
      shadow0_d   = shadow0_q;
      shadow1_d   = shadow1_q;
      shadow2_d   = shadow2_q;
      out0_d      = out0_q;
      out1_d      = out1_q;
      out2_d      = out2_q;
      out3_d      = out3_q;
      out_valid_d = 1'b0;
      sync_err_d  = 1'b0;
      cnt_en_s    = 1'b0;
      cnt_load1_s = 1'b0;
      cnt_clr_s   = 1'b0;

      if (IN_VALID) begin
         case (state_q)
            HUNT: begin
               // Only a sync beat can start a frame; anything else is noise.
               if (FSYNC) begin
                  shadow0_d   = IN;
                  cnt_load1_s = 1'b1;
                  state_d     = LOCK;
               end else begin
                  state_d     = HUNT;
               end
            end

            LOCK: begin
               if (FSYNC) begin
                  // Sync on slot 0 is the normal case. Sync anywhere else
                  // abandons the partial frame but keeps lock: the beat is
                  // trusted as the start of a new frame. Stale shadow1/2
                  // contents are overwritten before they can be published.
                  sync_err_d  = !slot0_s;
                  shadow0_d   = IN;
                  cnt_load1_s = 1'b1;
               end else if (slot0_s) begin
                  // Expected a sync here and did not get one: alignment lost,
                  // the beat is dropped.
                  sync_err_d  = 1'b1;
                  cnt_clr_s   = 1'b1;
                  state_d     = HUNT;
               end else if (last_s) begin
                  // Slot 3 goes straight to OUT3 so the frame publishes on
                  // the same edge that accepts its last beat.
                  out0_d      = shadow0_q;
                  out1_d      = shadow1_q;
                  out2_d      = shadow2_q;
                  out3_d      = IN;
                  out_valid_d = 1'b1;
                  cnt_en_s    = 1'b1;
               end else begin
                  case (sel_s)
                     SLOT_SECOND: shadow1_d = IN;
                     SLOT_THIRD:  shadow2_d = IN;
                     default:     shadow1_d = shadow1_q;
                  endcase
                  cnt_en_s    = 1'b1;
               end
            end

            default: begin
               state_d   = HUNT;
               cnt_clr_s = 1'b1;
            end
         endcase
      end else begin
         // Stall: hold everything, pulses stay low.
         state_d = state_q;
      end
   end

   // Alignment state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Shadow registers for slots 0..2 of the frame being assembled.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shadow0_q <= '0;
         shadow1_q <= '0;
         shadow2_q <= '0;
      end else begin
         shadow0_q <= shadow0_d;
         shadow1_q <= shadow1_d;
         shadow2_q <= shadow2_d;
      end
   end

   // Published frame; holds the last complete frame until reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out0_q <= '0;
         out1_q <= '0;
         out2_q <= '0;
         out3_q <= '0;
      end else begin
         out0_q <= out0_d;
         out1_q <= out1_d;
         out2_q <= out2_d;
         out3_q <= out3_d;
      end
   end

   // Single-cycle status pulses.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign OUT0      = out0_q;
   assign OUT1      = out1_q;
   assign OUT2      = out2_q;
   assign OUT3      = out3_q;
   assign OUT_VALID = out_valid_q;
   assign SYNC_ERR  = sync_err_q;
   assign SEL       = sel_s;
   assign LOCKED    = (state_q == LOCK);

endmodule
